// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port memory.
// The arbiter uses the slave modport; the requesters and memory model use master.
interface riscv_mem_arbiter_if;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_gnt_out;
    logic        if_rvalid_out;
    logic [31:0] if_rdata_out;

    logic        dm_req_in;
    logic        dm_we_in;
    logic [31:0] dm_addr_in;
    logic [31:0] dm_wdata_in;
    logic [2:0]  dm_size_in;
    logic        dm_gnt_out;
    logic        dm_rvalid_out;
    logic [31:0] dm_rdata_out;
    logic        dm_err_out;

    logic        mem_en_out;
    logic [3:0]  mem_we_out;
    logic [29:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_rdata_in;

    modport slave (
        input  if_req_in, if_addr_in,
        input  dm_req_in, dm_we_in, dm_addr_in, dm_wdata_in, dm_size_in,
        input  mem_rdata_in,
        output if_gnt_out, if_rvalid_out, if_rdata_out,
        output dm_gnt_out, dm_rvalid_out, dm_rdata_out, dm_err_out,
        output mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out
    );

    modport master (
        output if_req_in, if_addr_in,
        output dm_req_in, dm_we_in, dm_addr_in, dm_wdata_in, dm_size_in,
        output mem_rdata_in,
        input  if_gnt_out, if_rvalid_out, if_rdata_out,
        input  dm_gnt_out, dm_rvalid_out, dm_rdata_out, dm_err_out,
        input  mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter onto one pipelined memory port: data has priority with a starvation
// guard for fetch, load data is aligned/extended on return using a tag shift register.
module riscv_mem_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    riscv_mem_arbiter_if.slave bus
);
    localparam logic [2:0] MASK_NONE = 3'b000;
    localparam logic [2:0] MASK_B    = 3'b001;
    localparam logic [2:0] MASK_H    = 3'b010;
    localparam logic [2:0] MASK_W    = 3'b011;
    localparam logic [2:0] MASK_BU   = 3'b101;
    localparam logic [2:0] MASK_HU   = 3'b110;

    typedef struct packed {
        logic       valid;
        logic       owner;  // 1 = data port
        logic [2:0] size;
        logic [1:0] off;
    } tag_t;

    tag_t        r_tag [MEM_LATENCY];
    logic [3:0]  r_starve;

    logic        w_dm_win, w_dm_gnt, w_if_gnt, w_size_ok, w_dm_acc, w_dm_wr;
    logic [1:0]  w_off;
    logic [3:0]  w_strb;
    tag_t        w_push, w_out;
    logic        w_rvalid;
    logic [31:0] w_shift, w_ld;
    logic        w_unused_ok;

    assign w_off       = bus.dm_addr_in[1:0];
    assign w_unused_ok = ^bus.if_addr_in[1:0];

    always_comb begin
        w_size_ok = 1'b0;
        w_strb    = 4'b1111;
        case (bus.dm_size_in)
            MASK_B, MASK_BU: begin
                w_size_ok = 1'b1;
                w_strb    = 4'b0001 << w_off;
            end
            MASK_H, MASK_HU: begin
                w_size_ok = ~w_off[0];
                w_strb    = 4'b0011 << w_off;
            end
            MASK_W:    w_size_ok = (w_off == 2'b00);
            MASK_NONE: w_size_ok = 1'b0;
            default:   w_size_ok = 1'b0;
        endcase
    end

    // Fetch only beats a competing data request once the starvation counter has saturated.
    assign w_dm_win = bus.dm_req_in && (!bus.if_req_in || r_starve != 4'(STARVE_LIMIT));
    assign w_dm_gnt = !rst_in && w_dm_win;
    assign w_if_gnt = !rst_in && bus.if_req_in && !w_dm_win;
    assign w_dm_acc = w_dm_gnt && w_size_ok;
    assign w_dm_wr  = w_dm_acc && bus.dm_we_in;

    assign bus.if_gnt_out    = w_if_gnt;
    assign bus.dm_gnt_out    = w_dm_gnt;
    assign bus.dm_err_out    = w_dm_gnt && !w_size_ok;
    assign bus.mem_en_out    = w_if_gnt || w_dm_acc;
    assign bus.mem_we_out    = w_dm_wr ? w_strb : 4'b0000;
    assign bus.mem_addr_out  = w_if_gnt ? bus.if_addr_in[31:2] :
                               w_dm_acc ? bus.dm_addr_in[31:2] : 30'd0;
    assign bus.mem_wdata_out = w_dm_wr ? (bus.dm_wdata_in << {w_off, 3'b000}) : 32'd0;

    always_comb begin
        w_push       = '0;
        w_push.valid = w_if_gnt || (w_dm_acc && !bus.dm_we_in);
        w_push.owner = w_dm_acc;
        w_push.size  = bus.dm_size_in;
        w_push.off   = w_off;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < MEM_LATENCY; i++) r_tag[i] <= '0;
            r_starve <= 4'd0;
        end else begin
            r_tag[0] <= w_push;
            for (int i = 1; i < MEM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
            if (w_dm_gnt && bus.if_req_in)
                r_starve <= (r_starve == 4'(STARVE_LIMIT)) ? r_starve : r_starve + 4'd1;
            else
                r_starve <= 4'd0;
        end
    end

    assign w_out    = r_tag[MEM_LATENCY-1];
    assign w_rvalid = w_out.valid && !rst_in;
    assign w_shift  = bus.mem_rdata_in >> {w_out.off, 3'b000};

    always_comb begin
        case (w_out.size)
            MASK_B:  w_ld = {{24{w_shift[7]}}, w_shift[7:0]};
            MASK_BU: w_ld = {24'd0, w_shift[7:0]};
            MASK_H:  w_ld = {{16{w_shift[15]}}, w_shift[15:0]};
            MASK_HU: w_ld = {16'd0, w_shift[15:0]};
            default: w_ld = w_shift;
        endcase
    end

    assign bus.if_rvalid_out = w_rvalid && !w_out.owner;
    assign bus.if_rdata_out  = (w_rvalid && !w_out.owner) ? bus.mem_rdata_in : 32'd0;
    assign bus.dm_rvalid_out = w_rvalid && w_out.owner;
    assign bus.dm_rdata_out  = (w_rvalid && w_out.owner) ? w_ld : 32'd0;
endmodule
